// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed scan driver for a 4-digit FND.
// Each digit slot is a dark gap followed by a lit period. The BCD value
// and the leading-zero mode are captured once per frame, so a frame never
// mixes old and new digits.
module fnd_scan_controller #(
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_run,
  input  logic [15:0] i_value,
  input  logic        i_leadZeroBlank,
  output logic [1:0]  o_digitSelect,
  output logic        o_blank,
  output logic [3:0]  o_bcd,
  output logic        o_frameDone
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  scan_state_t      state_q, state_d;
  logic [1:0]       index_q, index_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      snap_q;
  logic             lzb_q;
  logic             frame_done_d;
  logic             snap_load;
  logic             upper_zero;

  // Next-state logic: blank gap, then lit period, then advance to the next digit.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    count_d      = count_q + 1'b1;
    frame_done_d = 1'b0;
    if (!i_run) begin
      state_d = ST_BLANK;
      index_d = 2'd0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (count_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            count_d = '0;
          end
        end
        ST_SHOW: begin
          if (count_q == SHOW_LAST) begin
            state_d      = ST_BLANK;
            count_d      = '0;
            index_d      = index_q + 2'd1;
            frame_done_d = (index_q == 2'd3);
          end
        end
        default: begin
          state_d = ST_BLANK;
          count_d = '0;
        end
      endcase
    end
  end

  // The very first cycle of a frame is the only point where new display data is taken.
  assign snap_load = i_run && (state_q == ST_BLANK) && (index_q == 2'd0) && (count_q == '0);

  // Scan state, frame pulse and per-frame snapshot registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_BLANK;
      index_q     <= 2'd0;
      count_q     <= '0;
      snap_q      <= 16'h0000;
      lzb_q       <= 1'b0;
      o_frameDone <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      count_q     <= count_d;
      o_frameDone <= frame_done_d;
      if (snap_load) begin
        snap_q <= i_value;
        lzb_q  <= i_leadZeroBlank;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    upper_zero = 1'b0;
    case (index_q)
      2'd1:    upper_zero = (snap_q[15:4] == 12'h000);
      2'd2:    upper_zero = (snap_q[15:8] == 8'h00);
      2'd3:    upper_zero = (snap_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign o_digitSelect = index_q;
  assign o_bcd         = snap_q[{index_q, 2'b00} +: 4];
  assign o_blank       = (state_q == ST_BLANK) || (lzb_q && upper_zero);

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: directed bench for the FND scan driver with a
// 2-cycle gap and 4-cycle lit period (6-cycle slot, 24-cycle frame).
module tb_fnd_scan_controller;

  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = SHOW + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] value;
  logic        lead_zero_blank;
  logic [1:0]  digit_select;
  logic        blank;
  logic [3:0]  bcd;
  logic        frame_done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Free-running 100 MHz-style clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  fnd_scan_controller #(
    .SHOW_CYCLES (SHOW),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_run          (run),
    .i_value        (value),
    .i_leadZeroBlank(lead_zero_blank),
    .o_digitSelect  (digit_select),
    .o_blank        (blank),
    .o_bcd          (bcd),
    .o_frameDone    (frame_done)
  );

  // Expected {sel, blank, bcd, frameDone} right after edge e of a run that
  // started from a clean frame start with snapshot val and mode lz.
  function automatic logic [7:0] expected(input int e, input logic [15:0] val, input logic lz);
    int          idx;
    int          pos;
    logic [15:0] shifted;
    logic        exp_blank;
    logic        exp_fd;
    idx       = (e / SLOT) % 4;
    pos       = e % SLOT;
    shifted   = val >> (4 * idx);
    exp_blank = (pos < BLANK) || (lz && (idx != 0) && (shifted == 16'h0000));
    exp_fd    = ((e % FRAME) == 0);
    return {idx[1:0], exp_blank, shifted[3:0], exp_fd};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {digit_select, blank, bcd, frame_done};
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed sel/blank/bcd/fd=%0d/%0b/%h/%0b expected=%0d/%0b/%h/%0b",
             tag, obs[7:6], obs[5], obs[4:1], obs[0], exp[7:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Step through edges first_e..last_e, checking every cycle against the model.
  task automatic applyStimulus(input int first_e, input int last_e, input logic [15:0] val,
                               input logic lz, input string tag);
    for (int e = first_e; e <= last_e; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s e%0d", tag, e), expected(e, val, lz));
    end
  endtask

  // Assert reset between edges, confirm the reset state, then release so
  // the next rising edge is edge 1 of a fresh run.
  task automatic restart(input string tag);
    reset_n = 1'b0;
    #1;
    checkOutput({tag, " in reset"}, {2'd0, 1'b1, 4'h0, 1'b0});
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b1;
    run             = 1'b1;
    value           = 16'h1234;
    lead_zero_blank = 1'b0;
    #1;

    // Asynchronous reset mid-SHOW of digit 2
    restart("t1 start");
    applyStimulus(1, 15, 16'h1234, 1'b0, "t1 pre");
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t1 async reset", {2'd0, 1'b1, 4'h0, 1'b0});

    // Normal scanning over two frames
    restart("t2");
    applyStimulus(1, 48, 16'h1234, 1'b0, "t2 scan");

    // Leading-zero suppression
    lead_zero_blank = 1'b1;
    value = 16'h0045;
    restart("t3a");
    applyStimulus(1, 24, 16'h0045, 1'b1, "t3 0045");
    value = 16'h0000;
    restart("t3b");
    applyStimulus(1, 24, 16'h0000, 1'b1, "t3 0000");
    value = 16'h0105;
    restart("t3c");
    applyStimulus(1, 24, 16'h0105, 1'b1, "t3 0105");
    lead_zero_blank = 1'b0;

    // Snapshot coherency and frame wrap boundary
    value = 16'h1234;
    restart("t4");
    applyStimulus(1, 9, 16'h1234, 1'b0, "t4 early");
    value = 16'h9876;
    applyStimulus(10, 24, 16'h1234, 1'b0, "t4 old frame");
    applyStimulus(25, 48, 16'h9876, 1'b0, "t4 new frame");

    // Run stop and restart
    value = 16'h1234;
    restart("t5");
    applyStimulus(1, 15, 16'h1234, 1'b0, "t5 pre");
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("t5 parked %0d", i), {2'd0, 1'b1, 4'h4, 1'b0});
    end
    value = 16'h5678;
    run   = 1'b1;
    applyStimulus(1, 30, 16'h5678, 1'b0, "t5 resumed");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
